// File: rtl/shift_seq_pkg.sv
// ============================================================================
// shift_seq_pkg : opcodes, FSM state type and default sizes for the shift
//                 operation sequencer.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package shift_seq_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_INV  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_op_sequencer_if.sv
// ============================================================================
// shift_op_sequencer_if : command/result handshakes plus status of the
//                         sequencer; master = command source, slave = sequencer.
// Revision              : 1.0
// ============================================================================
`default_nettype none

interface shift_op_sequencer_if #(
    parameter int WIDTH = shift_seq_pkg::DEF_WIDTH,
    parameter int CNT_W = shift_seq_pkg::DEF_CNT_W
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;
    logic [1:0]       step_ctrl;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_data, busy, step_ctrl
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data, res_ready,
        output cmd_ready, res_valid, res_data, busy, step_ctrl
    );

endinterface

`default_nettype wire

// File: rtl/shift_step_reg.sv
// ============================================================================
// shift_step_reg : WIDTH-bit register doing one load/shr/shl/complement per
//                  enabled clock. SHIFT_SEQ_ARITH_EN selects arithmetic shr.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module shift_step_reg
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             en,
    input  wire logic [1:0]       ctrl,
    input  wire logic [WIDTH-1:0] d_in,
    output logic      [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             fill_bit;

`ifdef SHIFT_SEQ_ARITH_EN
    assign fill_bit = q_q[WIDTH-1];
`else
    assign fill_bit = 1'b0;
`endif

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (ctrl)
                OP_LOAD: q_d = d_in;
                OP_SHR:  q_d = {fill_bit, q_q[WIDTH-1:1]};
                OP_SHL:  q_d = {q_q[WIDTH-2:0], 1'b0};
                default: q_d = ~q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_out = q_q;

endmodule

`default_nettype wire

// File: rtl/shift_op_sequencer.sv
// ============================================================================
// shift_op_sequencer : accepts one command, runs its steps on shift_step_reg
//                      and returns the result. Honors SHIFT_SEQ_ARITH_EN.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module shift_op_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    shift_op_sequencer_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_d;
    logic [1:0]       op_q;
    logic [1:0]       op_d;
    logic             dp_en;
    logic [1:0]       dp_ctrl;
    logic [WIDTH-1:0] dp_q;

    shift_step_reg #(
        .WIDTH (WIDTH)
    ) u_step_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (dp_en),
        .ctrl    (dp_ctrl),
        .d_in    (bus.cmd_data),
        .q_out   (dp_q)
    );

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        op_d          = op_q;
        dp_en         = 1'b0;
        dp_ctrl       = OP_LOAD;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.busy      = 1'b1;
        bus.step_ctrl = OP_LOAD;

        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) begin
                    dp_en = 1'b1;
                    op_d  = bus.cmd_op;
                    // Complement is a single step whatever the count says.
                    case (bus.cmd_op)
                        OP_SHR, OP_SHL: rem_d = bus.cmd_count;
                        OP_INV:         rem_d = CNT_W'(1);
                        default:        rem_d = '0;
                    endcase
                    state_d = (rem_d != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                dp_en         = 1'b1;
                dp_ctrl       = op_q;
                bus.step_ctrl = op_q;
                rem_d         = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            op_q    <= OP_LOAD;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    assign bus.res_data = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_op_sequencer.sv
// ============================================================================
// tb_shift_op_sequencer : directed commands with a result scoreboard checked
//                         by an independent monitor.
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_shift_op_sequencer;
    import shift_seq_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
`ifdef SHIFT_SEQ_ARITH_EN
    localparam bit ARITH = 1'b1;
`else
    localparam bit ARITH = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    shift_op_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_op_sequencer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   cyc        = 0;
    int   n_cmp      = 0;
    int   n_err      = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: first-valid cycle and result data against the scoreboard head.
    always @(negedge clk) begin
        if (bus.res_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got res_valid=1, expected 0 (cycle %0d)", cyc);
            end else begin
                chk("res_latency", cyc, sb[0].due);
            end
        end
        if (bus.res_valid && bus.res_ready && sb.size() != 0) begin
            chk("res_data", {28'd0, bus.res_data}, {28'd0, sb[0].data});
            void'(sb.pop_front());
        end
        prev_valid <= bus.res_valid;
    end

    task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                        input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_d,
                        input int n, output int waited);
        exp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_count = cnt;
        bus.cmd_data  = d;
        waited        = 0;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            waited++;
            if (waited > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL cmd_accept_timeout: got cmd_ready=0, expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        e.data = exp_d;
        e.due  = cyc + n;
        sb.push_back(e);
        // Scramble the inputs to prove the accepted command was latched.
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = ~op;
        bus.cmd_count = ~cnt;
        bus.cmd_data  = ~d;
    endtask

    task automatic check_steps(input logic [1:0] op, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("step_ctrl", {30'd0, bus.step_ctrl}, {30'd0, op});
            chk("busy_in_shift", {31'd0, bus.busy}, 32'd1);
            chk("cmd_ready_in_shift", {31'd0, bus.cmd_ready}, 32'd0);
        end
        @(negedge clk);
        chk("step_ctrl_done", {30'd0, bus.step_ctrl}, 32'd0);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                       input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_d, input int n);
        int w;
        send(op, cnt, d, exp_d, n, w);
        check_steps(op, n);
        drain();
    endtask

    task automatic check_reset_outputs();
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_res_data", {28'd0, bus.res_data}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_step_ctrl", {30'd0, bus.step_ctrl}, 32'd0);
    endtask

    initial begin
        int w;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_count = '0;
        bus.cmd_data  = '0;
        bus.res_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run(OP_LOAD, 3'd0, 4'b1011, 4'b1011, 0);
        run(OP_SHR,  3'd2, 4'b1100, ARITH ? 4'b1111 : 4'b0011, 2);
        run(OP_SHR,  3'd2, 4'b1000, ARITH ? 4'b1110 : 4'b0010, 2);
        run(OP_SHL,  3'd5, 4'b1111, 4'b0000, 5);
        run(OP_INV,  3'd6, 4'b0110, 4'b1001, 1);
        run(OP_SHR,  3'd7, 4'b1010, ARITH ? 4'b1111 : 4'b0000, 7);
        run(OP_LOAD, 3'd3, 4'b0101, 4'b0101, 0);
        run(OP_SHR,  3'd0, 4'b0110, 4'b0110, 0);

        // Backpressure with a competing command held during busy.
        bus.res_ready = 1'b0;
        send(OP_SHL, 3'd1, 4'b0011, 4'b0110, 1, w);
        check_steps(OP_SHL, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_count = 3'd0;
        bus.cmd_data  = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("bp_res_data", {28'd0, bus.res_data}, 32'h6);
            chk("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
            chk("bp_busy", {31'd0, bus.busy}, 32'd1);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        send(OP_LOAD, 3'd0, 4'b1001, 4'b1001, 0, w);
        chk("accept_after_handshake_wait", w, 32'd1);
        check_steps(OP_LOAD, 0);
        drain();

        // Reset in the middle of a count-7 shift discards the command.
        send(OP_SHR, 3'd7, 4'b1111, 4'b0000, 7, w);
        @(negedge clk);
        chk("pre_reset_step_ctrl", {30'd0, bus.step_ctrl}, {30'd0, OP_SHR});
        @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_reset_res_valid", {31'd0, bus.res_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        run(OP_INV, 3'd0, 4'b0000, 4'b1111, 1);
        run(OP_SHL, 3'd2, 4'b0101, 4'b0100, 2);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/shift_op_sequencer.md
# shift_op_sequencer

Command-driven controller that sequences a 4-bit shift/load/complement register over multiple cycles. It accepts one command (opcode, step count, operand) through a valid/ready handshake and loads the operand. It then applies the selected single-step operation once per clock for the requested number of steps and presents the result through a second valid/ready handshake. It sits between a command source (CPU-style register interface or test FSM) and the shifter datapath, and owns all control-code sequencing for that datapath.

## Interface
Parameters:
- WIDTH, 4, datapath width in bits
- CNT_W, 3, width of step count; max steps 2^CNT_W-1

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 load/pass, 01 right shift, 10 left shift, 11 complement
- cmd_count  in  CNT_W  number of shift steps (ops 01/10 only)
- cmd_data  in  WIDTH  operand
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  WIDTH  result
- busy  out  1  high when state is not IDLE
- step_ctrl  out  2  control code applied to the datapath this cycle; 00 when no step

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready:
  - Register loads cmd_data (code 00).
  - remaining = cmd_count for ops 01/10, 1 for op 11, 0 for op 00.
  - Next state is SHIFT if remaining!=0, else DONE.
- SHIFT: each cycle, one step with step_ctrl=cmd_op (latched); remaining decrements. On the edge where remaining reaches 0, go to DONE.
  - Right step: {fill, q[W-1:1]}.
  - Left step: {q[W-2:0], 0}.
  - Complement: ~q.
- DONE: res_valid=1, res_data=register. On res_valid&&res_ready go to IDLE.
- Step counts >= WIDTH are legal. Every step is still executed. Result: all zeros, or all-fill (see Configuration).
- cmd_valid outside IDLE is ignored; the source must hold it until accepted. Latched op/count/data are immune to input changes after accept.
- Reset at any edge with reset_n=0: state IDLE, register 0, remaining 0, latched op 00; in-flight command is discarded with no res_valid.

## Timing
- Reset values: cmd_ready=1, res_valid=0, res_data=0, busy=0, step_ctrl=00.
- Accept at edge k. Result valid from cycle k+1+n, where n = number of steps (0 for op 00, 1 for op 11, cmd_count for ops 01/10).
- res_data and res_valid are stable while res_valid&&!res_ready.
- After the result handshake at edge j, cmd_ready=1 in cycle j+1. There is no same-cycle result-to-command overlap. Minimum command spacing is n+2 cycles.
- cmd_ready=0 whenever busy=1.

## Configuration
- SHIFT_SEQ_ARITH_EN defined: right-shift fill bit = current q[W-1] (arithmetic).
- SHIFT_SEQ_ARITH_EN undefined: fill bit = 0 (logical).
- Left shift and complement are unaffected.

## Structure
- Package shift_seq_pkg:
  - Opcode constants OP_LOAD=2'b00, OP_SHR=2'b01, OP_SHL=2'b10, OP_INV=2'b11.
  - State enum (IDLE, SHIFT, DONE).
  - Default WIDTH/CNT_W.
- Sub-module shift_step_reg: registered datapath with clk, reset_n, en, ctrl[1:0], d_in, q_out.
  - Implements load/right/left/complement in one clock when en=1; holds otherwise.
  - Honors SHIFT_SEQ_ARITH_EN.
- shift_op_sequencer holds the FSM, remaining counter, latched op, and both handshakes.

## Test plan
- Reset, then op 00, data 4'b1011, res_ready=1 → res_valid in cycle after accept, res_data=1011, step_ctrl stays 00.
- Op 01, count 2, data 1100 → two cycles with step_ctrl=01, res_data=0011 at cycle k+3.
  - With SHIFT_SEQ_ARITH_EN, data 1000 → 1110.
- Op 10, count 5, data 1111 → five steps, res_data=0000.
- Op 11, count 6, data 0110 → exactly one step, res_data=1001.
- Backpressure and busy inputs:
  - Hold res_ready=0 for 4 cycles → res_valid/res_data steady, cmd_ready=0.
  - Drive a second cmd_valid with different data during busy → ignored, then accepted the cycle after the result handshake.
- Reset mid-shift: drop reset_n for one edge during SHIFT of a count-7 command → outputs at reset values next cycle, no res_valid, next command processes normally.
